sha256_stream: RTL
==================

# sha256_stream

Streaming, multi-block SHA-256/SHA-224 hash engine. It is the parametrised successor to the single-block hash top. The block accepts an arbitrary-length big-endian message as 32-bit words over a valid/ready handshake and performs FIPS 180-4 padding in hardware, including the extra-block case. It chains the intermediate hash across 512-bit blocks and runs one compression round per clock. It sits between the message source (DMA or register FIFO) and the digest consumer.

## Interface
- LEN_W, default 32: width of the message byte counter. Maximum message length is 2^LEN_W−1 bytes.
- SHA224_EN, default 1: when 0, `mode_224` is ignored and the block is SHA-256 only.
- clk, input, 1: single clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begins a new message. Sampled only in IDLE.
- mode_224, input, 1: selects SHA-224 IV and truncation. Latched on the `start` cycle.
- in_valid, input, 1: `in_data` is valid.
- in_ready, output, 1: the block can accept a word.
- in_data, input, 32: message word; byte 0 is in bits [31:24].
- in_last, input, 1: marks the final word of the message.
- in_bytes, input, 3: number of valid bytes (0–4) in the last word, MSB-aligned. Ignored on non-last words. Values 5–7 are treated as 4.
- busy, output, 1: high in every state except IDLE.
- digest_valid, output, 1: one-cycle pulse when the digest is ready.
- digest, output, 256: {H0..H7}. In SHA-224 mode H7 is forced to 0.
- err, output, 1: length overflow; pulses together with `digest_valid`.

## Operation
- States: IDLE, LOAD, PAD, ROUND, UPDATE, PAD2, DONE.
- IDLE:
  - `start`=1 latches the mode, clears the word index and byte counter, loads the H chain with the selected IV, and moves to LOAD.
  - SHA-256 IV: 6a09e667…5be0cd19.
  - SHA-224 IV: c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
- LOAD:
  - `in_ready`=1. Each handshake (`in_valid & in_ready`) writes W[idx], increments idx, and adds 4 (or `in_bytes` on the last word) to the byte counter.
  - When idx reaches 16 with no `in_last`, go to ROUND.
  - On `in_last`, go to PAD.
- Padding (PAD, one cycle):
  - If the last word has `in_bytes`<4, clear its unused bytes and place 0x80 in the first unused byte; p = index of that word.
  - Otherwise put 0x80000000 in word p = last+1.
  - If p ≤ 13: zero words p+1..13; W14/W15 = 64-bit bit length ({cnt,3'b0}, zero-extended); mark the block final.
  - If p is 14 or 15: zero the remainder and set the extra-block flag.
  - If p = 16: set the extra-block flag and the leading-0x80 flag.
  - Then go to ROUND.
- ROUND:
  - 64 cycles; round counter 0..63 selects K.
  - The schedule is a 16-word shift register: each cycle W0 feeds the round and W15 ← σ0(W1)+σ1(W14)+W9+W0.
  - Working variables a..h are loaded from the H chain on ROUND entry.
- UPDATE (one cycle): H_i ← H_i + working_i, all mod 2^32. Next state:
  - LOAD, if the message is not finished;
  - PAD2, if the extra-block flag is set;
  - DONE, if the block was final.
- PAD2 (one cycle):
  - W0 = 0x80000000 if the leading-0x80 flag is set, else 0.
  - W1..W13 = 0; W14/W15 = length.
  - Mark final and go to ROUND.
- DONE: `digest` ← H chain (H7 = 0 if SHA-224), `digest_valid`=1 for one cycle, then IDLE. `digest` holds its value until the next DONE.
- Byte counter:
  - Wraps mod 2^LEN_W.
  - A sticky overflow bit is set on wrap and drives `err` at DONE.
  - The overflow bit clears on `start`.
- `start` outside IDLE is ignored. `in_valid` outside LOAD is ignored (`in_ready`=0).
- An empty message is one last word with `in_bytes`=0.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `digest_valid`=0, `err`=0, `digest`=0; state IDLE; all registers cleared.
- Reset mid-operation aborts the hash immediately. There is no partial output.
- `start` at cycle S puts the block in LOAD at S+1, with `in_ready` high from S+1.
- `in_valid` may toggle freely. Stalls extend LOAD only.
- Let N be the cycle of the last-word handshake:
  - No extra block: PAD at N+1, ROUND at N+2..N+65, UPDATE at N+66, `digest_valid` at N+67.
  - Extra block: `digest_valid` at N+133.
- A full non-final block: `in_ready` drops the cycle after the 16th handshake and returns 65 cycles later (64 ROUND + 1 UPDATE).
- Back-to-back: `start` is accepted on the cycle after DONE (IDLE).

## Test plan
- "abc" (one word 0x61626300, `in_last`, `in_bytes`=3), SHA-256 → digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; `digest_valid` at N+67.
- Empty message (`in_bytes`=0) → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (14 words, p = 14, extra block) → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1 at N+133.
- `mode_224`=1, "abc" → 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, H7 field = 0.
- Exactly 64-byte message (p = 16) with random `in_valid` gaps → matches the reference model; `in_ready` low throughout ROUND/UPDATE; extra block starts with 0x80000000.
- `rst_n` low at round 30, then "abc" restarted → no `digest_valid` during the aborted hash; correct "abc" digest afterwards; `start` while busy is ignored.

Source files
------------

// File: rtl/sha256_stream.sv
// rtl/sha256_stream.sv - streaming SHA-256/SHA-224 engine with hardware padding
// Ports: clk/rst_n (async active-low); start + mode_224 begin a message;
// in_valid/in_ready/in_data/in_last/in_bytes carry big-endian message words;
// busy is high outside IDLE; digest_valid pulses with digest {H0..H7} and err
// (byte counter overflow).
module sha256_stream #(
    parameter int LEN_W     = 32,
    parameter bit SHA224_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode_224,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         busy,
    output logic         digest_valid,
    output logic [255:0] digest,
    output logic         err
);
    typedef enum logic [2:0] {IDLE, LOAD, PAD, ROUND, UPDATE, PAD2, DONE} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [3:0]      idx_q, idx_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [3:0]      lidx_q, lidx_d;
    logic [2:0]      lbytes_q, lbytes_d;
    logic [5:0]      rnd_q, rnd_d;
    logic            extra_q, extra_d;
    logic            lead80_q, lead80_d;
    logic            fin_q, fin_d;
    logic [255:0]    digest_q, digest_d;
    logic            dvalid_q, dvalid_d;
    logic            err_q, err_d;
    logic [31:0]     w_q [16];
    logic [31:0]     w_d [16];
    logic [31:0]     h_q [8];
    logic [31:0]     h_d [8];
    logic [31:0]     v_q [8];
    logic [31:0]     v_d [8];

    logic [31:0]     big_s0, big_s1, ch, maj, t1, t2, w_new;
    logic [2:0]      nb;
    logic [LEN_W:0]  cnt_sum;
    logic [63:0]     len64;
    logic [4:0]      p;

    // One compression round and one schedule step per clock.
    always_comb begin
        big_s1 = rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25);
        ch     = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
        t1     = v_q[7] + big_s1 + ch + K[rnd_q] + w_q[0];
        big_s0 = rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22);
        maj    = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
        t2     = big_s0 + maj;
        w_new  = (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
               + (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
               + w_q[9] + w_q[0];
    end

    assign nb      = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign cnt_sum = {1'b0, cnt_q} + {{(LEN_W - 2){1'b0}}, (in_last ? nb : 3'd4)};
    assign len64   = 64'(cnt_q) << 3;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        lidx_d   = lidx_q;
        lbytes_d = lbytes_q;
        rnd_d    = rnd_q;
        extra_d  = extra_q;
        lead80_d = lead80_q;
        fin_d    = fin_q;
        digest_d = digest_q;
        dvalid_d = 1'b0;
        err_d    = 1'b0;
        p        = 5'd0;
        for (int i = 0; i < 16; i++) w_d[i] = w_q[i];
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i];
        for (int i = 0; i < 8; i++) v_d[i] = v_q[i];

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = mode_224 & SHA224_EN;
                    idx_d    = 4'd0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    extra_d  = 1'b0;
                    lead80_d = 1'b0;
                    fin_d    = 1'b0;
                    for (int i = 0; i < 8; i++) h_d[i] = (mode_224 & SHA224_EN) ? IV224[i] : IV256[i];
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    w_d[idx_q] = in_data;
                    idx_d      = idx_q + 4'd1;
                    cnt_d      = cnt_sum[LEN_W-1:0];
                    if (cnt_sum[LEN_W]) ovf_d = 1'b1;
                    if (in_last) begin
                        lidx_d   = idx_q;
                        lbytes_d = nb;
                        state_d  = PAD;
                    end else if (idx_q == 4'd15) begin
                        for (int i = 0; i < 8; i++) v_d[i] = h_q[i];
                        rnd_d   = 6'd0;
                        state_d = ROUND;
                    end
                end
            end
            PAD: begin
                // p is the word that receives the 0x80 marker; 16 means it spills
                // into a second block.
                if (lbytes_q < 3'd4) begin
                    p = {1'b0, lidx_q};
                    case (lbytes_q[1:0])
                        2'd0:    w_d[lidx_q] = 32'h8000_0000;
                        2'd1:    w_d[lidx_q] = {w_q[lidx_q][31:24], 24'h80_0000};
                        2'd2:    w_d[lidx_q] = {w_q[lidx_q][31:16], 16'h8000};
                        default: w_d[lidx_q] = {w_q[lidx_q][31:8], 8'h80};
                    endcase
                end else begin
                    p = {1'b0, lidx_q} + 5'd1;
                    if (p < 5'd16) w_d[p[3:0]] = 32'h8000_0000;
                end
                for (int i = 0; i < 16; i++) if (5'(i) > p) w_d[i] = 32'h0;
                if (p <= 5'd13) begin
                    w_d[14] = len64[63:32];
                    w_d[15] = len64[31:0];
                    fin_d   = 1'b1;
                end else begin
                    extra_d  = 1'b1;
                    lead80_d = (p == 5'd16);
                end
                for (int i = 0; i < 8; i++) v_d[i] = h_q[i];
                rnd_d   = 6'd0;
                state_d = ROUND;
            end
            ROUND: begin
                v_d[0] = t1 + t2;
                v_d[1] = v_q[0];
                v_d[2] = v_q[1];
                v_d[3] = v_q[2];
                v_d[4] = v_q[3] + t1;
                v_d[5] = v_q[4];
                v_d[6] = v_q[5];
                v_d[7] = v_q[6];
                for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                w_d[15] = w_new;
                rnd_d   = rnd_q + 6'd1;
                if (rnd_q == 6'd63) state_d = UPDATE;
            end
            UPDATE: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
                if (fin_q) begin
                    for (int i = 0; i < 8; i++) digest_d[255-32*i -: 32] = h_d[i];
                    if (mode_q) digest_d[31:0] = 32'h0;
                    dvalid_d = 1'b1;
                    err_d    = ovf_q;
                    state_d  = DONE;
                end else if (extra_q) begin
                    state_d = PAD2;
                end else begin
                    idx_d   = 4'd0;
                    state_d = LOAD;
                end
            end
            PAD2: begin
                w_d[0] = lead80_q ? 32'h8000_0000 : 32'h0;
                for (int i = 1; i < 14; i++) w_d[i] = 32'h0;
                w_d[14] = len64[63:32];
                w_d[15] = len64[31:0];
                fin_d   = 1'b1;
                extra_d = 1'b0;
                for (int i = 0; i < 8; i++) v_d[i] = h_q[i];
                rnd_d   = 6'd0;
                state_d = ROUND;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            idx_q    <= 4'd0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            lidx_q   <= 4'd0;
            lbytes_q <= 3'd0;
            rnd_q    <= 6'd0;
            extra_q  <= 1'b0;
            lead80_q <= 1'b0;
            fin_q    <= 1'b0;
            digest_q <= '0;
            dvalid_q <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
            for (int i = 0; i < 8; i++) h_q[i] <= 32'h0;
            for (int i = 0; i < 8; i++) v_q[i] <= 32'h0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            lidx_q   <= lidx_d;
            lbytes_q <= lbytes_d;
            rnd_q    <= rnd_d;
            extra_q  <= extra_d;
            lead80_q <= lead80_d;
            fin_q    <= fin_d;
            digest_q <= digest_d;
            dvalid_q <= dvalid_d;
            err_q    <= err_d;
            for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
            for (int i = 0; i < 8; i++) h_q[i] <= h_d[i];
            for (int i = 0; i < 8; i++) v_q[i] <= v_d[i];
        end
    end

    assign in_ready     = (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign digest_valid = dvalid_q;
    assign digest       = digest_q;
    assign err          = err_q;
endmodule
